// File: rtl/vga_mem_pkg.sv
// vga_mem_pkg: shared types and default widths for the VGA/CPU framebuffer RAM arbiter
package vga_mem_pkg;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_VGA_RD,
        TAG_CPU_RD,
        TAG_CPU_WR
    } tag_e;
endpackage

// File: rtl/vga_arb_starve_ctr.sv
// vga_arb_starve_ctr: counts cycles an eligible CPU request loses to VGA and flags a forced CPU grant
//   clk_i, reset_i (async, active-high)
//   cpu_req_i  : CPU request level
//   cpu_busy_i : CPU ack cycle in progress (request not eligible)
//   vga_win_i  : VGA granted this cycle
//   cpu_gnt_i  : CPU granted this cycle
//   force_cpu_o: counter reached MAX_WAIT, CPU must win this cycle
module vga_arb_starve_ctr #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic cpu_req_i,
    input  logic cpu_busy_i,
    input  logic vga_win_i,
    input  logic cpu_gnt_i,
    output logic force_cpu_o
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = (!cpu_req_i || cpu_gnt_i) ? '0 :
                (vga_win_i && !cpu_busy_i && cnt_q != LIMIT) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
    assign force_cpu_o = (cnt_q == LIMIT);
endmodule

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: single-port RAM arbiter, VGA fetch has priority over CPU load/store
//   clk_i, reset_i (async, active-high)
//   vga_*  : VGA read request/address in, grant/rvalid/rdata out
//   cpu_*  : CPU request/we/address/wdata in, ack/rdata out
//   mem_*  : RAM enable/we/address/wdata out, rdata in (1-cycle read latency)
//   Optional macro VGA_ARB_STARVE_GUARD_EN adds MAX_WAIT starvation guard for the CPU.
module vga_mem_arbiter
    import vga_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
`ifdef VGA_ARB_STARVE_GUARD_EN
    parameter int MAX_WAIT = 8,
`endif
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              vga_req_i,
    input  logic [ADDR_W-1:0] vga_addr_i,
    output logic              vga_gnt_o,
    output logic              vga_rvalid_o,
    output logic [DATA_W-1:0] vga_rdata_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    tag_e tag_q, tag_d;
    logic cpu_busy, cpu_ok, force_cpu, gnt_vga, gnt_cpu;
    // A CPU tag means the held request is in its ack cycle and must not be re-granted
    assign cpu_busy = (tag_q == TAG_CPU_RD) || (tag_q == TAG_CPU_WR);
    assign cpu_ok   = cpu_req_i && !cpu_busy;
`ifdef VGA_ARB_STARVE_GUARD_EN
    logic force_raw;
    vga_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .cpu_req_i  (cpu_req_i),
        .cpu_busy_i (cpu_busy),
        .vga_win_i  (gnt_vga),
        .cpu_gnt_i  (gnt_cpu),
        .force_cpu_o(force_raw)
    );
    assign force_cpu = force_raw && cpu_ok;
`else
    assign force_cpu = 1'b0;
`endif
    always_comb begin
        gnt_vga     = !reset_i && vga_req_i && !force_cpu;
        gnt_cpu     = !reset_i && cpu_ok && (!vga_req_i || force_cpu);
        mem_en_o    = gnt_vga || gnt_cpu;
        mem_we_o    = gnt_cpu && cpu_we_i;
        mem_addr_o  = gnt_vga ? vga_addr_i : gnt_cpu ? cpu_addr_i : '0;
        mem_wdata_o = gnt_cpu ? cpu_wdata_i : '0;
        tag_d       = gnt_vga ? TAG_VGA_RD :
                      gnt_cpu ? (cpu_we_i ? TAG_CPU_WR : TAG_CPU_RD) : TAG_NONE;
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) tag_q <= TAG_NONE;
        else         tag_q <= tag_d;
    end
    assign vga_gnt_o    = gnt_vga;
    assign vga_rvalid_o = (tag_q == TAG_VGA_RD);
    assign cpu_ack_o    = cpu_busy;
    assign vga_rdata_o  = mem_rdata_i;
    assign cpu_rdata_o  = mem_rdata_i;
endmodule
